bsg_nonce_range_gen: RTL and testbench

Multi-channel nonce generator for the multicore SHA-256 miner. It is loaded once per job with a nonce range [start, limit). It then hands out every nonce in that range exactly once, interleaved across els_p hashing cores through per-channel valid/yumi handshakes. It supports an optional wrap mode for continuous search and an abort input for when a core reports a golden nonce.

---
 rtl/bsg_nonce_range_gen.sv | 106 ++++++++++
 tb/tb_bsg_nonce_range_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bsg_nonce_range_gen.sv
// Multi-channel nonce generator: hands out every nonce of [start, limit) exactly once
// across els_p channels, with optional wrap-around and abort.
module bsg_nonce_range_gen #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       cfg_v_i,
    output logic                       cfg_ready_o,
    input  logic [width_p-1:0]         cfg_start_i,
    input  logic [width_p-1:0]         cfg_limit_i,
    input  logic                       cfg_wrap_i,
    input  logic                       abort_i,
    output logic [els_p-1:0]           nonce_v_o,
    output logic [els_p*width_p-1:0]   nonce_o,
    input  logic [els_p-1:0]           nonce_yumi_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [width_p-1:0]         count_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [width_p:0] els_lp = (width_p+1)'(els_p);

    state_e                          state;
    logic [width_p-1:0]              start_r, limit_r, count_r;
    logic                            wrap_r;
    logic [els_p-1:0][width_p-1:0]   c_r, c_next, c_init;
    logic [els_p-1:0]                exh_r, exh_next, exh_init;
    logic [els_p-1:0]                active, take;
    logic [width_p-1:0]              take_cnt;
    logic [width_p:0]                nxt, first;

    // Sums are formed in width_p+1 bits so a carry out reads as ">= limit".
    always_comb begin
        active   = (state == RUN) ? ~exh_r : '0;
        take     = nonce_yumi_i & active;
        take_cnt = '0;
        c_next   = c_r;
        exh_next = exh_r;
        c_init   = '0;
        exh_init = '0;
        nxt      = '0;
        first    = '0;
        for (int unsigned k = 0; k < els_p; k++) begin
            first       = {1'b0, cfg_start_i} + (width_p+1)'(k);
            c_init[k]   = first[width_p-1:0];
            exh_init[k] = (first >= {1'b0, cfg_limit_i});
            nxt         = {1'b0, c_r[k]} + els_lp;
            if (take[k]) begin
                take_cnt = take_cnt + width_p'(1);
                if (nxt < {1'b0, limit_r})
                    c_next[k] = nxt[width_p-1:0];
                else if (wrap_r)
                    c_next[k] = start_r + width_p'(k);
                else
                    exh_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            start_r <= '0;
            limit_r <= '0;
            wrap_r  <= 1'b0;
            count_r <= '0;
            c_r     <= '0;
            exh_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_v_i) begin
                        start_r <= cfg_start_i;
                        limit_r <= cfg_limit_i;
                        wrap_r  <= cfg_wrap_i;
                        count_r <= '0;
                        c_r     <= c_init;
                        exh_r   <= exh_init;
                        state   <= (cfg_start_i >= cfg_limit_i) ? DONE : RUN;
                    end
                end
                RUN: begin
                    count_r <= count_r + take_cnt;
                    c_r     <= c_next;
                    exh_r   <= exh_next;
                    if (abort_i || (!wrap_r && (&exh_next)))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign nonce_v_o   = active;
    assign nonce_o     = c_r;
    assign busy_o      = (state == RUN);
    assign done_o      = (state == DONE);
    assign cfg_ready_o = (state == IDLE);
    assign count_o     = count_r;

endmodule

// File: tb/tb_bsg_nonce_range_gen.sv
// Table-driven bench for bsg_nonce_range_gen: each record drives one cycle of inputs
// and lists the outputs expected during that cycle.
module tb_bsg_nonce_range_gen;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         cfg_v_i;
    logic         cfg_ready_o;
    logic [31:0]  cfg_start_i, cfg_limit_i;
    logic         cfg_wrap_i;
    logic         abort_i;
    logic [3:0]   nonce_v_o;
    logic [127:0] nonce_o;
    logic [3:0]   nonce_yumi_i;
    logic         busy_o, done_o;
    logic [31:0]  count_o;

    int tests = 0;
    int fails = 0;

    bsg_nonce_range_gen #(.width_p(32), .els_p(4)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
        .cfg_start_i(cfg_start_i), .cfg_limit_i(cfg_limit_i), .cfg_wrap_i(cfg_wrap_i),
        .abort_i(abort_i), .nonce_v_o(nonce_v_o), .nonce_o(nonce_o),
        .nonce_yumi_i(nonce_yumi_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             cfg_v;
        logic [31:0]      start;
        logic [31:0]      limit;
        logic             wrap;
        logic [3:0]       yumi;
        logic             abort;
        logic [3:0]       ev;
        logic [3:0][31:0] en;
        logic             ebusy;
        logic             edone;
        logic             eready;
        logic [31:0]      ecount;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input logic cv, input logic [31:0] s, input logic [31:0] l,
                                input logic w, input logic [3:0] y, input logic ab,
                                input logic [3:0] ev, input logic [31:0] n0, input logic [31:0] n1,
                                input logic [31:0] n2, input logic [31:0] n3, input logic eb,
                                input logic ed, input logic er, input logic [31:0] ec);
        vec_t v;
        v.cfg_v = cv; v.start = s; v.limit = l; v.wrap = w; v.yumi = y; v.abort = ab;
        v.ev = ev; v.en[0] = n0; v.en[1] = n1; v.en[2] = n2; v.en[3] = n3;
        v.ebusy = eb; v.edone = ed; v.eready = er; v.ecount = ec;
        vecs.push_back(v);
    endfunction

    task automatic check_outputs(input string tag, input logic [3:0] ev, input logic [3:0][31:0] en,
                                 input logic eb, input logic ed, input logic er, input logic [31:0] ec);
        chk({tag, " valid"}, {28'd0, nonce_v_o}, {28'd0, ev});
        chk({tag, " busy"},  {31'd0, busy_o}, {31'd0, eb});
        chk({tag, " done"},  {31'd0, done_o}, {31'd0, ed});
        chk({tag, " ready"}, {31'd0, cfg_ready_o}, {31'd0, er});
        chk({tag, " count"}, count_o, ec);
        for (int k = 0; k < 4; k++)
            if (ev[k]) chk($sformatf("%s nonce%0d", tag, k), nonce_o[k*32 +: 32], en[k]);
    endtask

    initial begin
        // Job 1: one-shot [0,10)
        add(1, 0, 10, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 4'hF, 0, 4'hF, 0, 1, 2, 3, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'hF, 0, 4'hF, 4, 5, 6, 7, 1, 0, 0, 4);
        add(0, 0, 0, 0, 4'hF, 0, 4'h3, 8, 9, 0, 0, 1, 0, 0, 8);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 10);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 10);
        // Job 2: top-of-range carry
        add(1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 10);
        add(0, 0, 0, 0, 4'hF, 0, 4'hF, 32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'hF, 0, 4'h7, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 1, 0, 0, 4);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 7);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 7);
        // Job 3: wrap [100,102), then abort with two yumis
        add(1, 100, 102, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 7);
        add(0, 0, 0, 0, 4'h3, 0, 4'h3, 100, 101, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'h3, 0, 4'h3, 100, 101, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 4'hC, 0, 4'h3, 100, 101, 0, 0, 1, 0, 0, 4);
        add(0, 0, 0, 0, 4'h3, 1, 4'h3, 100, 101, 0, 0, 1, 0, 0, 4);
        add(0, 0, 0, 0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 6);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 6);
        // Job 4: empty range
        add(1, 5, 5, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 6);
        add(0, 0, 0, 0, 4'hF, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Job 5: backpressure, only ch2 accepts; late yumi on ch2 is illegal
        add(1, 0, 8, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 4'h4, 0, 4'hF, 0, 1, 2, 3, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'h4, 0, 4'hF, 0, 1, 6, 3, 1, 0, 0, 1);
        add(0, 0, 0, 0, 4'h4, 0, 4'hB, 0, 1, 0, 3, 1, 0, 0, 2);
        add(0, 0, 0, 0, 4'h0, 0, 4'hB, 0, 1, 0, 3, 1, 0, 0, 2);
        add(0, 0, 0, 0, 4'h0, 1, 4'hB, 0, 1, 0, 3, 1, 0, 0, 2);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 2);

        reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_start_i = '0; cfg_limit_i = '0;
        cfg_wrap_i = 1'b0; abort_i = 1'b0; nonce_yumi_i = '0;
        #1;
        check_outputs("reset", 4'h0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk_i);
            cfg_v_i = vecs[i].cfg_v; cfg_start_i = vecs[i].start; cfg_limit_i = vecs[i].limit;
            cfg_wrap_i = vecs[i].wrap; nonce_yumi_i = vecs[i].yumi; abort_i = vecs[i].abort;
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].ev, vecs[i].en, vecs[i].ebusy,
                          vecs[i].edone, vecs[i].eready, vecs[i].ecount);
        end

        // Asynchronous reset in the middle of a run
        @(negedge clk_i);
        cfg_v_i = 1'b1; cfg_start_i = 0; cfg_limit_i = 100; cfg_wrap_i = 1'b0;
        nonce_yumi_i = 4'h0; abort_i = 1'b0;
        @(negedge clk_i);
        cfg_v_i = 1'b0; nonce_yumi_i = 4'hF;
        @(negedge clk_i);
        #1;
        check_outputs("pre_rst", 4'hF, {32'd7, 32'd6, 32'd5, 32'd4}, 1'b1, 1'b0, 1'b0, 32'd4);
        #1;
        reset_n_i = 1'b0;
        #1;
        check_outputs("mid_rst", 4'h0, '0, 1'b0, 1'b0, 1'b1, 32'd0);
        @(posedge clk_i);
        #1;
        chk("rst_no_done", {31'd0, done_o}, 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1; nonce_yumi_i = 4'h0;
        @(negedge clk_i);
        cfg_v_i = 1'b1; cfg_start_i = 20; cfg_limit_i = 30;
        @(negedge clk_i);
        cfg_v_i = 1'b0;
        #1;
        check_outputs("post_rst", 4'hF, {32'd23, 32'd22, 32'd21, 32'd20}, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
